rhs2116_seq_ctrl: RTL and testbench



---
 rtl/rhs2116_pkg.sv | 35 +++
 rtl/rhs2116_tag_pipe.sv | 28 ++
 rtl/rhs2116_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rhs2116_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rhs2116_pkg.sv
// Shared definitions for the RHS2116 command scheduler: opcodes, tag types
// and command-word builders.
package rhs2116_pkg;

    localparam int         NUM_CHAN_DEF   = 16;
    localparam logic [7:0] FLUSH_ADDR_DEF = 8'd255;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;
    localparam logic [3:0] CONV_FLAGS = 4'b0010;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_CONV   = 2'd1,
        TAG_HREAD  = 2'd2,
        TAG_HWRITE = 2'd3
    } tag_type_e;

    typedef struct packed {
        logic      valid;
        tag_type_e typ;
        logic [7:0] idx;
    } tag_t;

    function automatic logic [31:0] conv_cmd(input logic [3:0] chan);
        return {OP_CONVERT, CONV_FLAGS, 4'b0000, 2'b00, chan, 16'h0000};
    endfunction

    function automatic logic [31:0] reg_cmd(input logic wr, input logic [7:0] addr,
                                            input logic [15:0] wdata);
        return wr ? {OP_WRITE, 6'b0, addr, wdata} : {OP_READ, 6'b0, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/rhs2116_tag_pipe.sv
// Three-deep tag history: entry 2 names the command whose data is arriving
// in the current frame (the chip answers two commands late).
module rhs2116_tag_pipe
    import rhs2116_pkg::*;
(
    input  logic clk_spi,
    input  logic rst_n,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic pop_i,
    output tag_t aged_tag_o
);

    tag_t [2:0] stage_q;

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (push_i) begin
            stage_q <= {stage_q[1:0], push_tag_i};
        end else if (pop_i) begin
            stage_q[2].valid <= 1'b0;
        end
    end

    assign aged_tag_o = stage_q[2];

endmodule

// File: rtl/rhs2116_seq_ctrl.sv
// RHS2116 command scheduler: round-robin CONVERTs interleaved with host
// register commands, tag-aligned result dispatch and drain-on-stop.
module rhs2116_seq_ctrl
    import rhs2116_pkg::*;
#(
    parameter int         NUM_CHAN   = NUM_CHAN_DEF,
    parameter logic [7:0] FLUSH_ADDR = FLUSH_ADDR_DEF
) (
    input  logic        clk_spi,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_req_write,
    input  logic [7:0]  host_req_addr,
    input  logic [15:0] host_req_wdata,
    output logic        host_rsp_valid,
    output logic [15:0] host_rsp_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_data,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        sample_valid,
    output logic [3:0]  sample_chan,
    output logic [15:0] sample_data,
    output logic        sweep_done,
    output logic        busy,
    output logic        proto_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;
    localparam logic [3:0] LAST_CHAN = 4'(NUM_CHAN - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  chan_q;
    logic        last_host_q, flush_wait_q, flush_second_q;
    logic        cmd_valid_q, host_req_ready_q, host_rsp_valid_q, sample_valid_q;
    logic        sweep_done_q, busy_q, proto_err_q;
    logic [31:0] cmd_data_q;
    logic [15:0] host_rsp_data_q, sample_data_q;
    logic [3:0]  sample_chan_q;
    tag_t        cur_tag_q, aged_tag;
    logic        hs, rsp_ok, load_host, load_conv, load_flush, aged_conv, aged_host;
    logic        unused_bits;

    rhs2116_tag_pipe u_tag_pipe (
        .clk_spi    (clk_spi),
        .rst_n      (rst_n),
        .push_i     (hs),
        .push_tag_i (cur_tag_q),
        .pop_i      (rsp_ok),
        .aged_tag_o (aged_tag)
    );

    assign aged_conv = aged_tag.valid && aged_tag.typ == TAG_CONV;
    assign aged_host = aged_tag.valid && (aged_tag.typ == TAG_HREAD || aged_tag.typ == TAG_HWRITE);
    assign unused_bits = ^{rsp_data[31:16], aged_tag.idx[7:4]};

    always_comb begin
        hs         = cmd_valid_q & cmd_ready;
        rsp_ok     = rsp_valid & ((state_q == S_WAIT) | ((state_q == S_FLUSH) & flush_wait_q));
        state_d    = state_q;
        load_host  = 1'b0;
        load_conv  = 1'b0;
        load_flush = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (host_req_valid) begin
                    load_host = 1'b1;
                    state_d   = S_ISSUE;
                end else if (enable) begin
                    load_conv = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: if (hs) state_d = S_WAIT;
            S_WAIT: begin
                if (rsp_valid) begin
                    // Host wins only if the previous slot was not already a host slot.
                    if (host_req_valid && !last_host_q) load_host  = 1'b1;
                    else if (enable)                    load_conv  = 1'b1;
                    else if (host_req_valid)            load_host  = 1'b1;
                    else                                load_flush = 1'b1;
                    state_d = load_flush ? S_FLUSH : S_ISSUE;
                end
            end
            default: begin
                if (rsp_ok) begin
                    if (flush_second_q) state_d    = S_IDLE;
                    else                load_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            chan_q           <= '0;
            last_host_q      <= 1'b0;
            flush_wait_q     <= 1'b0;
            flush_second_q   <= 1'b0;
            cur_tag_q        <= '0;
            cmd_valid_q      <= 1'b0;
            cmd_data_q       <= '0;
            host_req_ready_q <= 1'b0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_data_q  <= '0;
            sample_valid_q   <= 1'b0;
            sample_chan_q    <= '0;
            sample_data_q    <= '0;
            sweep_done_q     <= 1'b0;
            busy_q           <= 1'b0;
            proto_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy_q           <= state_d != S_IDLE;
            host_req_ready_q <= load_host;

            if (load_host) begin
                cmd_data_q <= reg_cmd(host_req_write, host_req_addr, host_req_wdata);
                cur_tag_q  <= '{valid: 1'b1, typ: host_req_write ? TAG_HWRITE : TAG_HREAD,
                               idx: host_req_addr};
            end else if (load_conv) begin
                cmd_data_q <= conv_cmd(chan_q);
                cur_tag_q  <= '{valid: 1'b1, typ: TAG_CONV, idx: {4'h0, chan_q}};
            end else if (load_flush) begin
                cmd_data_q <= reg_cmd(1'b0, FLUSH_ADDR, 16'h0000);
                cur_tag_q  <= '{valid: 1'b1, typ: TAG_NONE, idx: FLUSH_ADDR};
            end

            if (load_host || load_conv || load_flush) cmd_valid_q <= 1'b1;
            else if (hs)                              cmd_valid_q <= 1'b0;
            if (load_host || load_conv) last_host_q <= load_host;

            if (load_flush) begin
                flush_second_q <= state_q == S_FLUSH;
                flush_wait_q   <= 1'b0;
            end else if (hs && state_q == S_FLUSH) begin
                flush_wait_q   <= 1'b1;
            end

            if (hs && cur_tag_q.typ == TAG_CONV)
                chan_q <= (chan_q == LAST_CHAN) ? 4'd0 : chan_q + 4'd1;
            sweep_done_q <= hs && cur_tag_q.typ == TAG_CONV && chan_q == LAST_CHAN;

            sample_valid_q   <= rsp_ok && aged_conv;
            host_rsp_valid_q <= rsp_ok && aged_host;
            if (rsp_ok && aged_conv) begin
                sample_chan_q <= aged_tag.idx[3:0];
                sample_data_q <= rsp_data[15:0];
            end
            if (rsp_ok && aged_host) host_rsp_data_q <= rsp_data[15:0];

            if ((rsp_valid && !rsp_ok) || (cmd_ready && !cmd_valid_q)) proto_err_q <= 1'b1;
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_data       = cmd_data_q;
    assign host_req_ready = host_req_ready_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_data  = host_rsp_data_q;
    assign sample_valid   = sample_valid_q;
    assign sample_chan    = sample_chan_q;
    assign sample_data    = sample_data_q;
    assign sweep_done     = sweep_done_q;
    assign busy           = busy_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_rhs2116_seq_ctrl.sv
// Directed/randomized bench for rhs2116_seq_ctrl with a small engine model and
// a command-history scoreboard (frame k returns data for command k-2).
module tb_rhs2116_seq_ctrl;

    localparam int NCH = 4;

    logic        clk_spi = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic        host_req_write = 1'b0;
    logic [7:0]  host_req_addr = 8'h00;
    logic [15:0] host_req_wdata = 16'h0000;
    logic        host_rsp_valid;
    logic [15:0] host_rsp_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_data;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        sample_valid;
    logic [3:0]  sample_chan;
    logic [15:0] sample_data;
    logic        sweep_done;
    logic        busy;
    logic        proto_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] iss_w[$];
    int          iss_k[$];   // 0 = flush dummy, 1 = convert, 2 = host
    int          mchan = 0;

    rhs2116_seq_ctrl #(.NUM_CHAN(NCH), .FLUSH_ADDR(8'd255)) dut (
        .clk_spi(clk_spi), .rst_n(rst_n), .enable(enable),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_write(host_req_write), .host_req_addr(host_req_addr),
        .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
        .host_rsp_data(host_rsp_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
        .sweep_done(sweep_done), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk_spi = ~clk_spi;

    function automatic logic [31:0] conv_w(input int c);
        return 32'h0800_0000 | (32'(c) << 16);
    endfunction
    function automatic logic [31:0] rd_w(input logic [7:0] a);
        return 32'hC000_0000 | {8'h00, a, 16'h0000};
    endfunction
    function automatic logic [31:0] wr_w(input logic [7:0] a, input logic [15:0] d);
        return 32'h8000_0000 | {8'h00, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_data", cmd_data, 32'd0);
        chk("rst_host_req_ready", 32'(host_req_ready), 32'd0);
        chk("rst_host_rsp_valid", 32'(host_rsp_valid), 32'd0);
        chk("rst_host_rsp_data", 32'(host_rsp_data), 32'd0);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_chan", 32'(sample_chan), 32'd0);
        chk("rst_sample_data", 32'(sample_data), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
    endtask

    // One command through the engine: accept, respond, score the dispatched result.
    task automatic xact(input int kind, input logic [31:0] hw, input bit imm,
                        input bit drop_en, input bit host_keep, input bit no_rsp);
        logic [31:0] exp_w, ow;
        int t, k, pk;
        exp_w = (kind == 1) ? conv_w(mchan) : (kind == 2) ? hw : rd_w(8'hFF);
        if (imm) chk("cmd_latency", 32'(cmd_valid), 32'd1);
        t = 0;
        while (cmd_valid !== 1'b1 && t < 20) begin
            @(negedge clk_spi);
            t++;
        end
        chk("cmd_valid", 32'(cmd_valid), 32'd1);
        chk("cmd_data", cmd_data, exp_w);
        chk("busy", 32'(busy), 32'd1);
        chk("host_req_ready", 32'(host_req_ready), 32'(kind == 2));
        if (kind == 2) begin
            if (host_keep) host_req_wdata = 16'($urandom);
            else host_req_valid = 1'b0;
        end
        if (drop_en) enable = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk_spi);
            chk("cmd_hold", cmd_data, exp_w);
        end
        cmd_ready = 1'b1;
        @(negedge clk_spi);
        cmd_ready = 1'b0;
        chk("cmd_drop", 32'(cmd_valid), 32'd0);
        chk("sweep_done", 32'(sweep_done), 32'(kind == 1 && mchan == NCH - 1));
        iss_w.push_back(exp_w);
        iss_k.push_back(kind);
        if (kind == 1) mchan = (mchan + 1) % NCH;
        if (no_rsp) return;
        repeat ($urandom_range(0, 2)) @(negedge clk_spi);
        k = iss_w.size() - 1;
        rsp_valid = 1'b1;
        rsp_data  = {16'h0000, 16'hA000 + 16'(k)};
        @(negedge clk_spi);
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        pk = (k >= 2) ? iss_k[k-2] : 0;
        ow = (k >= 2) ? iss_w[k-2] : 32'h0;
        chk("sample_valid", 32'(sample_valid), 32'(pk == 1));
        chk("host_rsp_valid", 32'(host_rsp_valid), 32'(pk == 2));
        if (pk == 1) begin
            chk("sample_chan", 32'(sample_chan), 32'(ow[19:16]));
            chk("sample_data", 32'(sample_data), 32'hA000 + 32'(k));
        end
        if (pk == 2) chk("host_rsp_data", 32'(host_rsp_data), 32'hA000 + 32'(k));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_spi);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk_spi);

        // Streaming: two dropped frames, then channel-tagged samples.
        enable = 1'b1;
        @(negedge clk_spi);
        for (int i = 0; i < 6; i++) xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Host READ interleaved between converts.
        host_req_write = 1'b0;
        host_req_addr  = 8'h28;
        host_req_valid = 1'b1;
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(2, 32'hC028_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Continuously pending host WRITEs must alternate with converts.
        host_req_write = 1'b1;
        host_req_addr  = 8'h10;
        host_req_wdata = 16'($urandom);
        host_req_valid = 1'b1;
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            xact(2, wr_w(8'h10, host_req_wdata), 1'b1, 1'b0, i < 2, 1'b0);
            xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Stop mid-ISSUE: convert completes, then two flush reads drain the pipe.
        xact(1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        xact(0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("busy_after_flush", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_spi);
        chk("idle_no_cmd", 32'(cmd_valid), 32'd0);

        // Stray frame in IDLE: sticky protocol error, nothing dispatched.
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_BEEF;
        @(negedge clk_spi);
        rsp_valid = 1'b0;
        chk("proto_err_set", 32'(proto_err), 32'd1);
        chk("stray_sample", 32'(sample_valid), 32'd0);
        chk("stray_host_rsp", 32'(host_rsp_valid), 32'd0);
        repeat (3) @(negedge clk_spi);
        chk("proto_err_sticky", 32'(proto_err), 32'd1);

        // Restart (channel counter carries over), then reset during WAIT_RSP.
        enable = 1'b1;
        @(negedge clk_spi);
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk_reset_vals();
        iss_w.delete();
        iss_k.delete();
        mchan = 0;
        @(negedge clk_spi);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk_spi);
        for (int i = 0; i < 4; i++) xact(1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
